// File: rtl/sram_2147_ctl.sv
// Sequencer and round-robin two-port arbiter for a 4K x WIDTH bank of 2147 static RAMs.
// Optional power-up bank clear is compiled in with the SRAM_CTL_CLEAR_EN macro.
module sram_2147_ctl #(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [11:0]      a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_ack,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [11:0]      b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ack,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic [11:0]      ram_addr,
  output logic             ram_ce_n,
  output logic             ram_we_n,
  output logic [WIDTH-1:0] ram_di,
  input  logic [WIDTH-1:0] ram_do
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE,
    S_CLEAR
  } state_t;

  state_t           state_q;
  logic             last_b_q;
  logic             gnt_b_q;
  logic             we_q;
  logic [3:0]       cnt_q;
  logic             a_ack_q;
  logic             b_ack_q;
  logic             busy_q;
  logic             ce_n_q;
  logic             we_n_q;
  logic [11:0]      addr_q;
  logic [WIDTH-1:0] di_q;
  logic [WIDTH-1:0] rdata_q;
`ifdef SRAM_CTL_CLEAR_EN
  logic             clr_ph_q;
`endif

  logic             gnt_b_d;
  logic             we_d;
  logic [11:0]      addr_d;
  logic [WIDTH-1:0] di_d;
  logic [3:0]       cnt_d;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_b_d = b_req;
    if (a_req && b_req) begin
      gnt_b_d = ~last_b_q;
    end
    we_d   = gnt_b_d ? b_we    : a_we;
    addr_d = gnt_b_d ? b_addr  : a_addr;
    di_d   = gnt_b_d ? b_wdata : a_wdata;
    cnt_d  = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_b_q <= 1'b1;
      gnt_b_q  <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= 4'd0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      addr_q   <= 12'd0;
      di_q     <= '0;
      rdata_q  <= '0;
`ifdef SRAM_CTL_CLEAR_EN
      clr_ph_q <= 1'b0;
      state_q  <= S_CLEAR;
      ce_n_q   <= 1'b0;
      we_n_q   <= 1'b0;
      busy_q   <= 1'b1;
`else
      state_q  <= S_IDLE;
      ce_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      busy_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (a_req || b_req) begin
            state_q  <= S_SETUP;
            gnt_b_q  <= gnt_b_d;
            last_b_q <= gnt_b_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            di_q     <= di_d;
            ce_n_q   <= 1'b0;
            we_n_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_STROBE;
          cnt_q   <= 4'(WAIT_CYCLES);
          we_n_q  <= ~we_q;
        end
        S_STROBE: begin
          cnt_q <= cnt_d;
          if (cnt_d == 4'd0) begin
            state_q <= S_HOLD;
            we_n_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          // Chip stays enabled through HOLD, so ram_do is still driven at this edge.
          state_q <= S_DONE;
          ce_n_q  <= 1'b1;
          if (!we_q) begin
            rdata_q <= ram_do;
          end
          a_ack_q <= ~gnt_b_q;
          b_ack_q <= gnt_b_q;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
`ifdef SRAM_CTL_CLEAR_EN
        S_CLEAR: begin
          if (!clr_ph_q) begin
            we_n_q   <= 1'b1;
            clr_ph_q <= 1'b1;
          end else begin
            clr_ph_q <= 1'b0;
            if (addr_q == 12'hFFF) begin
              state_q <= S_IDLE;
              ce_n_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              addr_q <= addr_q + 12'd1;
              we_n_q <= 1'b0;
            end
          end
        end
`endif
        default: begin
          state_q <= S_IDLE;
          ce_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign ram_addr = addr_q;
  assign ram_ce_n = ce_n_q;
  assign ram_we_n = we_n_q;
  assign ram_di   = di_q;

endmodule
